cp_buf_arbiter: RTL and testbench

Two-client burst arbiter and sequencer for the 128x128 single-port SRAM buffer wrapper (Cp_BufWrap) in the AES_128 datapath. Client A is the plaintext/key loader and client B is the cipher engine. Each client issues read or write bursts of 1–4 beats. The block grants the single SRAM port round-robin, drives the wrapper's write and read ports one beat per cycle with an auto-incrementing address, and routes read data back to the owning client.

---
 rtl/cp_buf_pkg.sv | 17 +
 rtl/cp_rr_arb2.sv | 37 +++
 rtl/cp_buf_arbiter.sv | 160 ++++++++++++++++
 tb/tb_cp_buf_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp_buf_pkg.sv
// Shared types and constants for the two-client SRAM buffer arbiter.
// Imported by the arbiter top and its round-robin picker.
package cp_buf_pkg;

  localparam int unsigned AW    = 7;
  localparam int unsigned DW    = 128;
  localparam int unsigned LEN_W = 2;

  localparam logic CLIENT_A = 1'b0;
  localparam logic CLIENT_B = 1'b1;

  typedef enum logic {
    StIdle,
    StXfer
  } state_e;

endpackage

// File: rtl/cp_rr_arb2.sv
// Two-way round-robin picker. ptr holds the last client served; on a tie the
// other client wins. ptr advances only when the owner strobes upd.
module cp_rr_arb2
  import cp_buf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt,
  output logic       ptr
);

  logic ptr_q;

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (ptr_q == CLIENT_B) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Reset to "B served last" so A takes the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= CLIENT_B;
    end else if (upd && (gnt != 2'b00)) begin
      ptr_q <= gnt[1];
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/cp_buf_arbiter.sv
// Burst arbiter/sequencer sharing one single-port SRAM wrapper between two
// clients: round-robin grant, one beat per cycle, tagged read return.
module cp_buf_arbiter #(
  parameter int unsigned AW     = 7,
  parameter int unsigned DW     = 128,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          iClk,
  input  logic          iRst,
  // client A
  input  logic          iAReq,
  input  logic          iAWr,
  input  logic [AW-1:0] iAAddr,
  input  logic [1:0]    iALen,
  input  logic [3:0]    iAWdSel,
  input  logic [DW-1:0] iAWrDt,
  output logic          oAAck,
  output logic          oARdVld,
  // client B
  input  logic          iBReq,
  input  logic          iBWr,
  input  logic [AW-1:0] iBAddr,
  input  logic [1:0]    iBLen,
  input  logic [3:0]    iBWdSel,
  input  logic [DW-1:0] iBWrDt,
  output logic          oBAck,
  output logic          oBRdVld,
  // shared read data
  output logic [DW-1:0] oRdDt,
  // wrapper write port
  output logic          oWrEn,
  output logic [3:0]    oWdSel,
  output logic [AW-1:0] oWrAddr,
  output logic [DW-1:0] oWrDt,
  // wrapper read port
  output logic          oRdEn,
  output logic [AW-1:0] oRdAddr,
  input  logic [DW-1:0] iRdDt,
  // status
  output logic          oBusy,
  output logic          oOwner
);

  import cp_buf_pkg::*;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             wr_q, wr_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;

  logic [1:0]       req;
  logic [1:0]       gnt;
  logic             arb_upd;
  logic             arb_ptr;
  logic             rd_beat;

  logic [RD_LAT-1:0] rd_vld_q;
  logic [RD_LAT-1:0] rd_tag_q;
  logic              rd_ret;
  logic              rd_owner;

  assign req = {iBReq, iAReq};

  cp_rr_arb2 u_arb (
    .clk (iClk),
    .rst (iRst),
    .req (req),
    .upd (arb_upd),
    .gnt (gnt),
    .ptr (arb_ptr)
  );

  // During XFER the arbiter pointer equals the burst owner, since it was
  // updated on the same edge as the grant; it steers the beat muxes.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    arb_upd = 1'b0;
    rd_beat = 1'b0;
    oAAck   = 1'b0;
    oBAck   = 1'b0;
    oWrEn   = 1'b0;
    oWdSel  = '0;
    oWrAddr = '0;
    oWrDt   = '0;
    oRdEn   = 1'b0;
    oRdAddr = '0;

    unique case (state_q)
      StIdle: begin
        if (gnt != 2'b00) begin
          arb_upd = 1'b1;
          owner_d = gnt[1];
          wr_d    = gnt[1] ? iBWr   : iAWr;
          addr_d  = gnt[1] ? iBAddr : iAAddr;
          cnt_d   = gnt[1] ? iBLen  : iALen;
          state_d = StXfer;
        end
      end

      StXfer: begin
        oAAck = (arb_ptr == CLIENT_A);
        oBAck = (arb_ptr == CLIENT_B);
        if (wr_q) begin
          oWrEn   = 1'b1;
          oWrAddr = addr_q;
          oWrDt   = (arb_ptr == CLIENT_B) ? iBWrDt  : iAWrDt;
          oWdSel  = (arb_ptr == CLIENT_B) ? iBWdSel : iAWdSel;
        end else begin
          oRdEn   = 1'b1;
          oRdAddr = addr_q;
          rd_beat = 1'b1;
        end
        addr_d = addr_q + AW'(1);
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q  <= StIdle;
      owner_q  <= CLIENT_A;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      cnt_q    <= '0;
      rd_vld_q <= '0;
      rd_tag_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      // Shift register matching the wrapper read latency.
      rd_vld_q <= RD_LAT'({rd_vld_q, rd_beat});
      rd_tag_q <= RD_LAT'({rd_tag_q, arb_ptr});
    end
  end

  assign rd_ret   = rd_vld_q[RD_LAT-1];
  assign rd_owner = rd_tag_q[RD_LAT-1];

  assign oARdVld = rd_ret && (rd_owner == CLIENT_A);
  assign oBRdVld = rd_ret && (rd_owner == CLIENT_B);
  assign oRdDt   = rd_ret ? iRdDt : '0;
  assign oBusy   = (state_q != StIdle);
  assign oOwner  = owner_q;

endmodule

// File: tb/tb_cp_buf_arbiter.sv
// Scoreboard bench: a cycle-level arbitration model predicts every beat and
// read return; a negedge monitor compares them against the DUT.
module tb_cp_buf_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]   req = '0;
  logic [1:0]   wr  = '0;
  logic [6:0]   addr_in [2];
  logic [1:0]   len_in  [2];
  logic [3:0]   sel_in  [2];
  logic [127:0] wdat_in [2];

  logic         a_ack, b_ack, a_vld, b_vld, wr_en, rd_en, busy, owner;
  logic [127:0] rd_dt, wr_dt, sram_q;
  logic [3:0]   wd_sel;
  logic [6:0]   wr_addr, rd_addr;

  cp_buf_arbiter dut (
    .iClk    (clk),
    .iRst    (rst),
    .iAReq   (req[0]),
    .iAWr    (wr[0]),
    .iAAddr  (addr_in[0]),
    .iALen   (len_in[0]),
    .iAWdSel (sel_in[0]),
    .iAWrDt  (wdat_in[0]),
    .oAAck   (a_ack),
    .oARdVld (a_vld),
    .iBReq   (req[1]),
    .iBWr    (wr[1]),
    .iBAddr  (addr_in[1]),
    .iBLen   (len_in[1]),
    .iBWdSel (sel_in[1]),
    .iBWrDt  (wdat_in[1]),
    .oBAck   (b_ack),
    .oBRdVld (b_vld),
    .oRdDt   (rd_dt),
    .oWrEn   (wr_en),
    .oWdSel  (wd_sel),
    .oWrAddr (wr_addr),
    .oWrDt   (wr_dt),
    .oRdEn   (rd_en),
    .oRdAddr (rd_addr),
    .iRdDt   (sram_q),
    .oBusy   (busy),
    .oOwner  (owner)
  );

  function automatic logic [127:0] init_word(int i);
    return {32'(i) * 32'h9E3779B1, ~32'(i), 32'hA5A50000 | 32'(i), 32'(i) ^ 32'h5A5A1234};
  endfunction

  // Wrapper stand-in: 4 x 32-bit word-select writes, 1-cycle read latency.
  logic [127:0] mem [128];
  bit mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 128; i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (wr_en) begin
      for (int w = 0; w < 4; w++) if (wd_sel[w]) mem[wr_addr][32*w +: 32] <= wr_dt[32*w +: 32];
    end
    if (rd_en) sram_q <= mem[rd_addr];
  end

  // Burst descriptors published by the drivers when they raise req.
  bit           d_wr   [2];
  logic [6:0]   d_addr [2];
  logic [1:0]   d_len  [2];
  logic [3:0]   d_sel  [2];
  logic [127:0] d_data [2][4];

  typedef struct {
    int           cyc;
    int           cl;
    bit           wr;
    logic [6:0]   addr;
    logic [3:0]   sel;
    logic [127:0] data;
  } beat_t;
  typedef struct {
    int           cyc;
    int           cl;
    logic [127:0] data;
  } ret_t;

  beat_t        beat_q[$];
  ret_t         ret_q[$];
  logic [127:0] ref_mem [128];
  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, ncyc, got, exp);
    end
  endtask

  // Monitor + reference model.
  initial begin : monitor
    beat_t      b;
    ret_t       r;
    int         win;
    int         last;
    int         exp_owner;
    int         free_cyc;
    logic [6:0] ba;
    last = 1; exp_owner = 0; free_cyc = 0;
    for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      if (mon_en) begin
        ncyc++;
        chk("wr_rd_exclusive", wr_en & rd_en, 0);
        if (beat_q.size() > 0 && beat_q[0].cyc == ncyc) begin
          b = beat_q.pop_front();
          chk("a_ack", a_ack, b.cl == 0);
          chk("b_ack", b_ack, b.cl == 1);
          chk("busy_beat", busy, 1);
          chk("owner_beat", owner, b.cl);
          chk("wr_en", wr_en, b.wr);
          chk("rd_en", rd_en, !b.wr);
          if (b.wr) begin
            chk("wr_addr", wr_addr, b.addr);
            chk("wr_dt", wr_dt, b.data);
            chk("wd_sel", wd_sel, b.sel);
            for (int w = 0; w < 4; w++)
              if (b.sel[w]) ref_mem[b.addr][32*w +: 32] = b.data[32*w +: 32];
          end else begin
            chk("rd_addr", rd_addr, b.addr);
            ret_q.push_back('{cyc: ncyc + 1, cl: b.cl, data: ref_mem[b.addr]});
          end
        end else begin
          chk("idle_acks", {a_ack, b_ack}, 0);
          chk("idle_busy", busy, 0);
          chk("idle_en", {wr_en, rd_en}, 0);
          chk("idle_addr", {wr_addr, rd_addr, wd_sel}, 0);
          chk("idle_wr_dt", wr_dt, 0);
          chk("idle_owner", owner, exp_owner);
        end
        if (ret_q.size() > 0 && ret_q[0].cyc == ncyc) begin
          r = ret_q.pop_front();
          chk("a_rd_vld", a_vld, r.cl == 0);
          chk("b_rd_vld", b_vld, r.cl == 1);
          chk("rd_dt", rd_dt, r.data);
        end else begin
          chk("no_rd_vld", {a_vld, b_vld}, 0);
          chk("rd_dt_zero", rd_dt, 0);
        end
        if (rst) begin
          beat_q.delete();
          ret_q.delete();
          last = 1; exp_owner = 0; free_cyc = ncyc + 1;
        end else if (ncyc >= free_cyc && req != 2'b00) begin
          if (req == 2'b11) win = (last == 1) ? 0 : 1;
          else win = req[1] ? 1 : 0;
          last = win; exp_owner = win;
          for (int k = 0; k <= int'(d_len[win]); k++) begin
            ba = d_addr[win] + 7'(k);
            beat_q.push_back('{cyc: ncyc + 1 + k, cl: win, wr: d_wr[win], addr: ba,
                               sel: d_sel[win], data: d_data[win][k]});
          end
          free_cyc = ncyc + int'(d_len[win]) + 2;
        end
      end
    end
  end

  // Call at posedge+#1. keep leaves req high so the next burst is arbitrated
  // in the bubble cycle.
  task automatic drive(input int c, input bit w, input logic [6:0] a, input logic [1:0] l,
                       input logic [3:0] s, input bit keep);
    int beat;
    int waited;
    bit aborted;
    for (int k = 0; k < 4; k++) d_data[c][k] = {$urandom, $urandom, $urandom, $urandom};
    d_wr[c] = w; d_addr[c] = a; d_len[c] = l; d_sel[c] = s;
    wr[c] = w; addr_in[c] = a; len_in[c] = l; sel_in[c] = s; wdat_in[c] = d_data[c][0];
    req[c] = 1'b1;
    beat = 0; waited = 0; aborted = 1'b0;
    while (beat <= int'(l) && waited < 300) begin
      @(negedge clk);
      if (rst) begin aborted = 1'b1; break; end
      if (c == 0 ? a_ack : b_ack) beat++;
      waited++;
      @(posedge clk); #1;
      if (beat <= int'(l)) wdat_in[c] = d_data[c][beat];
    end
    if (aborted) begin
      @(posedge clk); #1;
    end else begin
      chk("burst_beats", beat, int'(l) + 1);
    end
    if (!keep || aborted) req[c] = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin : stim
    int g;
    for (int c = 0; c < 2; c++) begin
      addr_in[c] = '0; len_in[c] = '0; sel_in[c] = '0; wdat_in[c] = '0;
      d_wr[c] = 1'b0; d_addr[c] = '0; d_len[c] = '0; d_sel[c] = '0;
    end
    step(1);
    mon_en = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);

    // A write 0x10..0x13 then read it back
    drive(0, 1'b1, 7'h10, 2'd3, 4'hF, 1'b0);
    drive(0, 1'b0, 7'h10, 2'd3, 4'hF, 1'b0);
    step(2);

    // Simultaneous requests, then A alone, then a tie B must take
    fork
      drive(0, 1'b1, 7'h30, 2'd1, 4'hF, 1'b0);
      drive(1, 1'b1, 7'h40, 2'd2, 4'hF, 1'b0);
    join
    drive(0, 1'b0, 7'h30, 2'd1, 4'hF, 1'b0);
    fork
      drive(0, 1'b0, 7'h40, 2'd2, 4'hF, 1'b0);
      drive(1, 1'b0, 7'h30, 2'd1, 4'hF, 1'b0);
    join
    step(1);

    // B read across the 127 -> 0 wrap
    drive(1, 1'b0, 7'h7E, 2'd3, 4'hF, 1'b0);
    step(1);

    // Partial word-select write over a pre-filled word
    drive(0, 1'b1, 7'h50, 2'd0, 4'hF, 1'b0);
    drive(0, 1'b1, 7'h50, 2'd0, 4'b0101, 1'b0);
    drive(0, 1'b0, 7'h50, 2'd0, 4'hF, 1'b0);
    step(1);

    // Reset during beat 2 of a 4-beat read
    fork
      drive(0, 1'b0, 7'h20, 2'd3, 4'hF, 1'b0);
      begin
        g = 0;
        do begin @(negedge clk); g++; end while (!a_ack && g < 50);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
      end
    join
    step(1);
    fork
      drive(0, 1'b0, 7'h10, 2'd1, 4'hF, 1'b0);
      drive(1, 1'b1, 7'h60, 2'd0, 4'hF, 1'b0);
    join
    step(1);

    // Read then write back-to-back from A
    drive(0, 1'b0, 7'h60, 2'd2, 4'hF, 1'b1);
    drive(0, 1'b1, 7'h61, 2'd2, 4'hF, 1'b0);
    step(1);

    // Random concurrent traffic
    fork
      for (int i = 0; i < 14; i++) begin
        step($urandom_range(0, 3));
        drive(0, 1'($urandom), 7'($urandom), 2'($urandom), 4'($urandom), 1'b0);
      end
      for (int j = 0; j < 14; j++) begin
        step($urandom_range(0, 3));
        drive(1, 1'($urandom), 7'($urandom), 2'($urandom), 4'($urandom), 1'b0);
      end
    join

    g = 0;
    while ((beat_q.size() + ret_q.size()) != 0 && g < 200) begin
      @(posedge clk); g++;
    end
    step(3);
    chk("drain", beat_q.size() + ret_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
